fwd_scoreboard: RTL and testbench

- Parametrised successor to the single-operand forwarding mux.
- Resolves NREAD source operands at the issue stage against NSTAGE prioritised bypass sources.
- Keeps a per-register countdown scoreboard for long-latency writers (mul/div) and raises an issue stall when a used operand is not yet obtainable.
- Sits between the register file read and the issue/EX boundary.

---
 rtl/fwd_scoreboard.sv | 124 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - issue-stage operand forwarding with long-latency countdown scoreboard
module fwd_scoreboard #(
   parameter int DW     = 64,
   parameter int AW     = 5,
   parameter int NREAD  = 2,
   parameter int NSTAGE = 2,
   parameter int CW     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREAD*AW-1:0]  rd_addr,
   input  logic [NREAD-1:0]     rd_use,
   input  logic [NREAD*DW-1:0]  rd_rf_dat,
   output logic [NREAD*DW-1:0]  rd_operand,
   output logic [NREAD-1:0]     rd_ready,
   input  logic [NSTAGE*AW-1:0] byp_rd,
   input  logic [NSTAGE-1:0]    byp_we,
   input  logic [NSTAGE-1:0]    byp_valid,
   input  logic [NSTAGE*DW-1:0] byp_dat,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic                 iss_we,
   input  logic [CW-1:0]        iss_lat,
   input  logic                 flush,
   output logic                 stall,
   output logic [31:0]          stall_cnt
);

   localparam int NREG = 1 << AW;

   // x0 has no counter; entries 1..NREG-1 count down to the cycle a result is bypassable
   logic [CW-1:0] cnt_q [1:NREG-1];
   logic [CW-1:0] cnt_d [1:NREG-1];
   logic [31:0]   stall_cnt_q;
   logic [31:0]   stall_cnt_d;
   logic          fire;

   for (genvar k = 0; k < NREAD; k++) begin : g_port
      logic [AW-1:0] addr;
      logic          busy;
      logic          hit;
      logic [DW-1:0] op;
      logic          rdy;

      assign addr = rd_addr[k*AW +: AW];

      // Look up whether this port's register still has a long-latency writer in flight
      always_comb begin
         busy = 1'b0;
         for (int r = 1; r < NREG; r++) begin
            if (addr == AW'(r) && cnt_q[r] != '0) begin
               busy = 1'b1;
            end
         end
      end

      // Resolve operand: x0, then youngest matching bypass, then scoreboard, then RF
      always_comb begin
         hit = 1'b0;
         op  = rd_rf_dat[k*DW +: DW];
         rdy = 1'b1;
         // Walk oldest to youngest so the youngest match is the one that sticks
         for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (byp_we[s] && byp_rd[s*AW +: AW] == addr) begin
               hit = 1'b1;
               op  = byp_dat[s*DW +: DW];
               rdy = byp_valid[s];
            end
         end
         // x0 reads zero and also masks any x0 writer on the bypass network
         if (addr == '0) begin
            op  = '0;
            rdy = 1'b1;
         end else if (!hit && busy) begin
            rdy = 1'b0;
         end
      end

      assign rd_operand[k*DW +: DW] = op;
      assign rd_ready[k]            = rdy;
   end

   assign stall     = iss_valid & |(rd_use & ~rd_ready);
   assign fire      = iss_valid & ~stall & ~flush;
   assign stall_cnt = stall_cnt_q;

   // Next counter values: flush kills all, a tracked issue overrides the decrement
   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (flush) begin
            cnt_d[r] = '0;
         end else if (fire && iss_we && iss_rd == AW'(r) && iss_lat != '0) begin
            cnt_d[r] = iss_lat;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
         end
      end
   end

   // Saturating stalled-cycle counter, insensitive to flush
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Scoreboard and statistics registers; reset drops all pending tracking at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
   localparam int DW = 64, AW = 5, NREAD = 2, NSTAGE = 2, CW = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREAD*AW-1:0]  rd_addr;
   logic [NREAD-1:0]     rd_use;
   logic [NREAD*DW-1:0]  rd_rf_dat;
   logic [NREAD*DW-1:0]  rd_operand;
   logic [NREAD-1:0]     rd_ready;
   logic [NSTAGE*AW-1:0] byp_rd;
   logic [NSTAGE-1:0]    byp_we;
   logic [NSTAGE-1:0]    byp_valid;
   logic [NSTAGE*DW-1:0] byp_dat;
   logic                 iss_valid;
   logic [AW-1:0]        iss_rd;
   logic                 iss_we;
   logic [CW-1:0]        iss_lat;
   logic                 flush;
   logic                 stall;
   logic [31:0]          stall_cnt;

   int tests = 0;
   int fails = 0;

   localparam logic [DW-1:0] VA = 64'hAAAA_0000_1111_2222;
   localparam logic [DW-1:0] VB = 64'hBBBB_3333_4444_5555;
   localparam logic [DW-1:0] D0 = 64'hD0D0_0000_0000_00D0;
   localparam logic [DW-1:0] D1 = 64'hD1D1_1111_1111_11D1;
   localparam logic [DW-1:0] R0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [DW-1:0] R1 = 64'hFEDC_BA98_7654_3210;

   fwd_scoreboard #(.DW(DW), .AW(AW), .NREAD(NREAD), .NSTAGE(NSTAGE), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_use     (rd_use),
      .rd_rf_dat  (rd_rf_dat),
      .rd_operand (rd_operand),
      .rd_ready   (rd_ready),
      .byp_rd     (byp_rd),
      .byp_we     (byp_we),
      .byp_valid  (byp_valid),
      .byp_dat    (byp_dat),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .iss_we     (iss_we),
      .iss_lat    (iss_lat),
      .flush      (flush),
      .stall      (stall),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle();
      rd_addr   = '0;
      rd_use    = '0;
      rd_rf_dat = '0;
      byp_rd    = '0;
      byp_we    = '0;
      byp_valid = '0;
      byp_dat   = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      iss_we    = 1'b0;
      iss_lat   = '0;
      flush     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      rd_addr   = {5'd5, 5'd0};
      rd_rf_dat = {VA, VB};
      rd_use    = 2'b11;
      iss_valid = 1'b1;
      #1;
      tests++; if (rd_operand !== {VA, 64'd0}) begin fails++; $display("FAIL reset_operand got=%h exp=%h", rd_operand, {VA, 64'd0}); end
      tests++; if (rd_ready !== 2'b11) begin fails++; $display("FAIL reset_ready got=%b exp=11", rd_ready); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
      tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
      @(negedge clk);
      rst = 1'b0;
      idle();
   endtask

   task automatic test_priority();
      @(negedge clk);
      idle();
      byp_rd    = {5'd7, 5'd7};
      byp_we    = 2'b11;
      byp_valid = 2'b11;
      byp_dat   = {D1, D0};
      rd_addr   = {5'd0, 5'd7};
      rd_rf_dat = {64'd0, R0};
      rd_use    = 2'b01;
      iss_valid = 1'b1;
      #1;
      tests++; if (rd_operand[DW-1:0] !== D0) begin fails++; $display("FAIL prio_youngest got=%h exp=%h", rd_operand[DW-1:0], D0); end
      tests++; if (rd_ready !== 2'b11 || stall !== 1'b0) begin fails++; $display("FAIL prio_ready got=%b/%b exp=11/0", rd_ready, stall); end
      byp_valid = 2'b10;
      #1;
      tests++; if (rd_ready[0] !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL prio_invalid got=%b/%b exp=0/1", rd_ready[0], stall); end
      tests++; if (rd_operand[DW-1:0] !== D0) begin fails++; $display("FAIL prio_older_ignored got=%h exp=%h", rd_operand[DW-1:0], D0); end
      rd_use = 2'b00;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL prio_unused got=%b exp=0", stall); end
      byp_valid = 2'b11;
      byp_we    = 2'b10;
      #1;
      tests++; if (rd_operand[DW-1:0] !== D1) begin fails++; $display("FAIL prio_src1 got=%h exp=%h", rd_operand[DW-1:0], D1); end
      @(negedge clk);
      idle();
      byp_rd    = {5'd0, 5'd0};
      byp_we    = 2'b11;
      byp_valid = 2'b11;
      byp_dat   = {D1, D0};
      rd_addr   = {5'd0, 5'd7};
      rd_rf_dat = {R1, R0};
      #1;
      tests++; if (rd_operand !== {64'd0, R0}) begin fails++; $display("FAIL prio_x0_writer got=%h exp=%h", rd_operand, {64'd0, R0}); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd9;
      iss_we    = 1'b1;
      iss_lat   = 3'd3;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_fire_stall got=%b exp=0", stall); end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         idle();
         iss_valid = 1'b1;
         rd_addr   = {5'd9, 5'd0};
         rd_use    = 2'b10;
         rd_rf_dat = {R1, 64'd0};
         #1;
         tests++;
         if (stall !== (c <= 3) || rd_ready[1] !== (c > 3)) begin
            fails++;
            $display("FAIL sb_cycle%0d stall/ready got=%b/%b exp=%b/%b", c, stall, rd_ready[1], (c <= 3), (c > 3));
         end
      end
      tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL sb_stall_cnt got=%0d exp=3", stall_cnt); end
      tests++; if (rd_operand[2*DW-1:DW] !== R1) begin fails++; $display("FAIL sb_operand got=%h exp=%h", rd_operand[2*DW-1:DW], R1); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd12;
      iss_we    = 1'b1;
      iss_lat   = 3'd7;
      @(negedge clk);
      idle();
      flush   = 1'b1;
      rd_addr = {5'd12, 5'd0};
      #1;
      tests++; if (rd_ready[1] !== 1'b0) begin fails++; $display("FAIL flush_tracked got=%b exp=0", rd_ready[1]); end
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      rd_addr   = {5'd12, 5'd0};
      rd_use    = 2'b10;
      #1;
      tests++; if (rd_ready[1] !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL flush_cleared got=%b/%b exp=1/0", rd_ready[1], stall); end
   endtask

   task automatic test_same_edge();
      int bad;
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      iss_we    = 1'b1;
      iss_lat   = 3'd2;
      @(negedge clk);
      idle();
      rd_addr = {5'd4, 5'd0};
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      iss_we    = 1'b1;
      iss_lat   = 3'd2;
      rd_addr   = {5'd4, 5'd0};
      #1;
      tests++; if (rd_ready[1] !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL same_edge_pre got=%b/%b exp=0/0", rd_ready[1], stall); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         idle();
         rd_addr = {5'd4, 5'd0};
         #1;
         tests++;
         if (rd_ready[1] !== (c == 3)) begin
            fails++;
            $display("FAIL same_edge_cycle%0d ready got=%b exp=%b", c, rd_ready[1], (c == 3));
         end
      end
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd0;
      iss_we    = 1'b1;
      iss_lat   = 3'd5;
      @(negedge clk);
      idle();
      bad = 0;
      for (int r = 0; r < 32; r++) begin
         rd_addr = {5'd0, 5'(r)};
         #0.1;
         if (rd_ready[0] !== 1'b1) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL x0_issue busy_regs got=%0d exp=0", bad); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd9;
      iss_we    = 1'b1;
      iss_lat   = 3'd5;
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      rd_addr   = {5'd9, 5'd0};
      rd_use    = 2'b10;
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL arst_pre_stall got=%b exp=1", stall); end
      @(posedge clk);
      #2;
      tests++; if (stall_cnt !== 32'd4 || stall !== 1'b1) begin fails++; $display("FAIL arst_pre_cnt got=%0d/%b exp=4/1", stall_cnt, stall); end
      rst = 1'b1;
      #1;
      tests++; if (stall !== 1'b0 || rd_ready !== 2'b11) begin fails++; $display("FAIL arst_stall got=%b/%b exp=0/11", stall, rd_ready); end
      tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL arst_stall_cnt got=%0d exp=0", stall_cnt); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL arst_release got=%b exp=0", stall); end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_scoreboard();
      test_flush();
      test_same_edge();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
